scan_config_loader: RTL

Configuration-chain master for the overlay fabric. Accepts a bitstream as a stream of words from the host interface and serialises it LSB-first into the fabric scan chain (the daisy-chained SIN/SOUT/SE path through switch blocks and connection blocks of every tile). After loading, it recirculates the chain once to read the configuration back non-destructively and checks a CRC-16 of the readback against the CRC of the loaded data. It sits at the chain head, driving the first tile's SIN and SE and receiving the last tile's SOUT.

---
 rtl/scan_config_loader_if.sv | 24 ++
 rtl/scan_config_loader.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/scan_config_loader_if.sv
// Host-side bitstream stream into the scan configuration loader:
// a start request plus a valid/ready word channel.
interface scan_config_loader_if #(
  parameter int WORD_W = 8
);
  logic              START;
  logic [WORD_W-1:0] DIN;
  logic              DIN_VALID;
  logic              DIN_READY;

  modport master (
    output START,
    output DIN,
    output DIN_VALID,
    input  DIN_READY
  );

  modport slave (
    input  START,
    input  DIN,
    input  DIN_VALID,
    output DIN_READY
  );
endinterface

// File: rtl/scan_config_loader.sv
// Scan-chain configuration master: serialises host words LSB-first into the fabric
// chain, then recirculates the chain once and compares a readback CRC-16 against the load CRC.
module scan_config_loader #(
  parameter int CHAIN_LEN = 1024,
  parameter int WORD_W    = 8,
  parameter int CNT_W     = 16
) (
  input  logic                 PCLK,
  input  logic                 RESET,
  scan_config_loader_if.slave  host,
  output logic                 SE,
  output logic                 CHAIN_SIN,
  input  logic                 CHAIN_SOUT,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 ERROR,
  output logic [15:0]          CRC_OUT
);

  localparam int BC_W = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] LEN_C    = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] LAST_C   = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [BC_W-1:0]  BUF_ZERO = {BC_W{1'b0}};
  localparam logic [BC_W-1:0]  BUF_ONE  = {{(BC_W-1){1'b0}}, 1'b1};
  localparam logic [BC_W-1:0]  BUF_FULL = BC_W'(WORD_W);
  localparam logic [BC_W-1:0]  BUF_M1   = BC_W'(WORD_W - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    VERIFY = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [WORD_W-1:0] buf_data;
  logic [BC_W-1:0]   buf_cnt;
  logic [15:0]       crc_load;
  logic [15:0]       crc_rb;
  logic              se_q;
  logic              sin_q;

  logic              buf_empty;
  logic              buf_last;
  logic              room;
  logic              ready;
  logic              xfer;
  logic              issue;
  logic              issue_bit;

  // CRC-16/CCITT single-bit update, MSB-first register
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din_bit);
    logic fb;
    fb = crc[15] ^ din_bit;
    return {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  // Word-buffer handshake and selection of the bit issued this cycle
  always_comb begin
    buf_empty = (buf_cnt == BUF_ZERO);
    buf_last  = (buf_cnt == BUF_ONE);
    room      = (bit_cnt < LEN_C);
    ready     = (state == LOAD) && room && (buf_empty || buf_last);
    xfer      = ready && host.DIN_VALID;
    // An empty buffer is bypassed so the first bit of a fresh word goes out on acceptance
    issue     = (state == LOAD) && room && (!buf_empty || xfer);
    issue_bit = buf_empty ? host.DIN[0] : buf_data[0];
  end

  assign host.DIN_READY = ready;
  assign SE             = se_q;
  assign CHAIN_SIN      = (state == VERIFY) ? CHAIN_SOUT : sin_q;

  // Sequencer: load, verify recirculation, result capture
  always_ff @(posedge PCLK) begin
    if (RESET) begin
      state    <= IDLE;
      bit_cnt  <= CNT_ZERO;
      buf_data <= {WORD_W{1'b0}};
      buf_cnt  <= BUF_ZERO;
      crc_load <= 16'hFFFF;
      crc_rb   <= 16'hFFFF;
      se_q     <= 1'b0;
      sin_q    <= 1'b0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      ERROR    <= 1'b0;
      CRC_OUT  <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          se_q <= 1'b0;
          if (host.START) begin
            state    <= LOAD;
            bit_cnt  <= CNT_ZERO;
            buf_data <= {WORD_W{1'b0}};
            buf_cnt  <= BUF_ZERO;
            crc_load <= 16'hFFFF;
            crc_rb   <= 16'hFFFF;
            BUSY     <= 1'b1;
            DONE     <= 1'b0;
            ERROR    <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end
        LOAD: begin
          if (!room) begin
            // Last loaded bit is shifting in now; leftover buffer bits are dropped
            state   <= VERIFY;
            bit_cnt <= CNT_ZERO;
            buf_cnt <= BUF_ZERO;
            se_q    <= 1'b1;
            sin_q   <= 1'b0;
          end else begin
            se_q <= issue;
            if (issue) begin
              sin_q    <= issue_bit;
              bit_cnt  <= bit_cnt + CNT_ONE;
              crc_load <= crc16_step(crc_load, issue_bit);
            end else begin
              sin_q <= sin_q;
            end
            if (xfer && !buf_empty) begin
              buf_data <= host.DIN;
              buf_cnt  <= BUF_FULL;
            end else if (xfer) begin
              buf_data <= {1'b0, host.DIN[WORD_W-1:1]};
              buf_cnt  <= BUF_M1;
            end else if (!buf_empty) begin
              buf_data <= {1'b0, buf_data[WORD_W-1:1]};
              buf_cnt  <= buf_cnt - BUF_ONE;
            end else begin
              buf_data <= buf_data;
              buf_cnt  <= buf_cnt;
            end
          end
        end
        VERIFY: begin
          crc_rb <= crc16_step(crc_rb, CHAIN_SOUT);
          if (bit_cnt == LAST_C) begin
            state <= FINISH;
            se_q  <= 1'b0;
            BUSY  <= 1'b0;
          end else begin
            bit_cnt <= bit_cnt + CNT_ONE;
          end
        end
        FINISH: begin
          state   <= IDLE;
          DONE    <= 1'b1;
          ERROR   <= (crc_rb != crc_load);
          CRC_OUT <= crc_load;
        end
        default: begin
          state <= IDLE;
          se_q  <= 1'b0;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule
